mult_rr_scheduler: RTL

Round-robin scheduler that shares one combinational 4x4 binary multiplier among NREQ requesters. It accepts one request at a time over a per-requester valid/ready handshake and drives the multiplier operands from registers. It captures the product and returns it, tagged with the requester index, over a valid/ready result port. It sits between requester blocks and the shared multiplier, which is connected externally through the mul_* ports.

---
 rtl/mult_rr_scheduler.sv | 93 +++++++++
 1 files changed

// File: rtl/mult_rr_scheduler.sv
// rtl/mult_rr_scheduler.sv - round-robin scheduler sharing one external multiplier among NREQ requesters
module mult_rr_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [2*WIDTH-1:0]    mul_p,
  output logic                  res_valid,
  output logic [2*WIDTH-1:0]    res_p,
  output logic [IDW-1:0]        res_id,
  input  logic                  res_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant;
  logic [IDW:0]   cand;
  logic           found;
  logic           window;
  logic           accept;

  // Rotating priority search: first valid requester at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ))
        cand = cand - (IDW+1)'(NREQ);
      if (!found && req_valid[cand[IDW-1:0]]) begin
        found = 1'b1;
        grant = cand[IDW-1:0];
      end
    end
  end

  assign window    = (state == IDLE) || ((state == DONE) && res_ready);
  assign accept    = window && found && !rst;
  assign req_ready = accept ? (NREQ'(1) << grant) : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      res_valid <= 1'b0;
      res_p     <= '0;
    end else begin
      case (state)
        IDLE: if (accept) state <= MUL;
        MUL: begin
          res_p     <= mul_p;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= accept ? MUL : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operands, owner tag and pointer move only on an accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= '0;
      mul_a  <= '0;
      mul_b  <= '0;
      res_id <= '0;
    end else if (accept) begin
      ptr    <= (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
      mul_a  <= req_a[grant*WIDTH +: WIDTH];
      mul_b  <= req_b[grant*WIDTH +: WIDTH];
      res_id <= grant;
    end
  end

endmodule
